// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: CPU fetch port, CPU data port,
// single-port SRAM control and the fetch stall counter. The arbiter uses the
// slave view; the surrounding system (CPU + SRAM) uses the master view.
interface unified_mem_arbiter_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 16
);
  // Instruction-fetch port
  logic              i_req;
  logic [AWIDTH-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DWIDTH-1:0] i_rdata;

  // Data-access port (d_wen: 0 = write, 1 = read)
  logic              d_req;
  logic              d_wen;
  logic [3:0]        d_be;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DWIDTH-1:0] d_rdata;

  // Single-port SRAM side (csn/wen active-low)
  logic              m_csn;
  logic              m_wen;
  logic [3:0]        m_be;
  logic [AWIDTH-1:0] m_addr;
  logic [DWIDTH-1:0] m_di;
  logic [DWIDTH-1:0] m_dout;

  // Performance counter
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_wen, d_be, d_addr, d_wdata,
    input  m_dout,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_csn, m_wen, m_be, m_addr, m_di,
    output stall_cnt
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_wen, d_be, d_addr, d_wdata,
    output m_dout,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_csn, m_wen, m_be, m_addr, m_di,
    input  stall_cnt
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM (1-cycle synchronous read) between the CPU
// fetch port and the data port. The data port wins by default; a starvation
// counter forces a fetch through after STARVE_LIMIT consecutive data grants.
// Read data returns one cycle after the grant, steered by a registered owner.
module unified_mem_arbiter #(
  parameter int AWIDTH       = 12,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Owner of the read data arriving next cycle. Encoding keeps each valid
  // as a single flop bit.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  owner_t           owner;
  owner_t           owner_next;
  logic [SW-1:0]    starve;
  logic [CNT_W-1:0] stall_cnt;

  logic i_req_ok;
  logic d_req_ok;
  logic i_gnt;
  logic d_gnt;

  logic              m_csn;
  logic              m_wen;
  logic [3:0]        m_be;
  logic [AWIDTH-1:0] m_addr;
  logic [DWIDTH-1:0] m_di;

  // Requests are masked while reset is held so the SRAM is deselected and
  // no grant is visible during reset.
  assign i_req_ok = bus.i_req & ~rst;
  assign d_req_ok = bus.d_req & ~rst;

  // Data port wins a tie unless fetch has been passed over STARVE_LIMIT times.
  assign i_gnt = i_req_ok & (~d_req_ok | (starve == STARVE_MAX));
  assign d_gnt = d_req_ok & ~i_gnt;

  // SRAM control for the winning requester; idle values when nobody wins.
  always_comb begin
    m_csn  = 1'b1;
    m_wen  = 1'b1;
    m_be   = 4'b0000;
    m_addr = '0;
    m_di   = '0;
    if (i_gnt) begin
      m_csn  = 1'b0;
      m_wen  = 1'b1;
      m_be   = 4'b1111;
      m_addr = bus.i_addr;
    end else if (d_gnt) begin
      m_csn  = 1'b0;
      m_wen  = bus.d_wen;
      m_be   = bus.d_be;
      m_addr = bus.d_addr;
      m_di   = bus.d_wdata;
    end
  end

  // Who receives the SRAM output next cycle: fetch, data read, or nobody
  // (idle or data write).
  always_comb begin
    owner_next = OWN_NONE;
    if (i_gnt) begin
      owner_next = OWN_I;
    end else if (d_gnt && bus.d_wen) begin
      owner_next = OWN_D;
    end
  end

  // Owner register and starvation counter; reset drops any pending return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= OWN_NONE;
      starve <= '0;
    end else begin
      owner <= owner_next;
      if (i_gnt || !i_req_ok) begin
        starve <= '0;
      end else if (d_gnt && (starve != STARVE_MAX)) begin
        starve <= starve + 1'b1;
      end
    end
  end

  // Saturating count of cycles where fetch asked but was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (i_req_ok && !i_gnt && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.m_csn     = m_csn;
  assign bus.m_wen     = m_wen;
  assign bus.m_be      = m_be;
  assign bus.m_addr    = m_addr;
  assign bus.m_di      = m_di;
  assign bus.stall_cnt = stall_cnt;

  // Return path: SRAM output routed to the registered owner, zero otherwise.
  assign bus.i_rvalid = (owner == OWN_I);
  assign bus.d_rvalid = (owner == OWN_D);
  assign bus.i_rdata  = (owner == OWN_I) ? bus.m_dout : '0;
  assign bus.d_rdata  = (owner == OWN_D) ? bus.m_dout : '0;

endmodule
